// File: rtl/navic_boc_pkg.sv
// navic_boc_pkg
// Shared constants and helpers for the NavIC L1 pilot BOC modulator.
//   SBOC_PERIOD    : chips per synthesized-BOC block (33)
//   SBOC_SLOTS     : slot indices within a block that use BOC(6,1): {0, 4, 6, 29}
//   BOC61_SEGMENTS : BOC(6,1) half-periods per chip (12)
//   PHASE_W        : number of NCO MSBs used as the subcarrier phase tap (8)
// The SBOC helpers are only referenced when NAVIC_BOC_SBOC_EN is defined.
package navic_boc_pkg;

    localparam int SBOC_PERIOD    = 33;
    localparam int SBOC_NUM_SLOTS = 4;
    localparam int SLOT_W         = 6;
    localparam int BOC61_SEGMENTS = 12;
    localparam int PHASE_W        = 8;
    localparam int PROD_W         = 12;

    // Packed list of the SBOC slots, entry i at bits [i*SLOT_W +: SLOT_W].
    localparam logic [SBOC_NUM_SLOTS*SLOT_W-1:0] SBOC_SLOTS =
        {6'd29, 6'd6, 6'd4, 6'd0};

    function automatic logic isSbocSlot(input logic [SLOT_W-1:0] slot);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < SBOC_NUM_SLOTS; i++) begin
            if (slot == SBOC_SLOTS[i*SLOT_W +: SLOT_W]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // BOC(6,1) sign: segment = (phase * 12) >> 8 and the subcarrier is its LSB,
    // which is bit PHASE_W of the product.
    function automatic logic boc61Subcarrier(input logic [PHASE_W-1:0] phase);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(phase) * PROD_W'(BOC61_SEGMENTS);
        return prod[PHASE_W];
    endfunction

endpackage

// File: rtl/navic_chip_nco.sv
// navic_chip_nco
// Chip-rate phase accumulator. Issues one tick per chip when the accumulator
// carries out, and exposes the top PHASE_W bits of the phase for subcarrier
// generation.
// Ports:
//   clk      : sample clock, rising edge
//   reset    : asynchronous active-high reset, clears the phase
//   en_i     : run enable; accumulator holds and no tick while low
//   fcw_i    : phase increment per clock, clamped to 2^(FCW_W-1)
//   tick_o   : combinational chip strobe (en_i & carry)
//   phase_o  : registered accumulator MSBs
module navic_chip_nco
    import navic_boc_pkg::*;
#(
    parameter int FCW_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic [FCW_W-1:0]   fcw_i,
    output logic               tick_o,
    output logic [PHASE_W-1:0] phase_o
);

    localparam logic [FCW_W-1:0] FCW_MAX = {1'b1, {(FCW_W-1){1'b0}}};

    logic [FCW_W-1:0] acc_q;
    logic [FCW_W-1:0] acc_d;
    logic [FCW_W-1:0] fcwEff;
    logic             carry;

    // Clamping to half the phase circle keeps ticks at least two clocks apart.
    always_comb begin
        fcwEff = (fcw_i > FCW_MAX) ? FCW_MAX : fcw_i;
        {carry, acc_d} = {1'b0, acc_q} + {1'b0, fcwEff};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign tick_o  = en_i & carry;
    assign phase_o = acc_q[FCW_W-1 -: PHASE_W];

endmodule

// File: rtl/navic_boc_modulator.sv
// navic_boc_modulator
// Chip timing and BOC subcarrier stage following the NavIC L1 pilot code
// generator. The NCO tick advances the generator; the returned chip is latched
// one clock later and XORed with a BOC(1,1) or, in synthesized-BOC slots, a
// BOC(6,1) subcarrier to give one sign-bit sample per clock.
// Configuration macro: NAVIC_BOC_SBOC_EN enables the SBOC slot counter and
// BOC(6,1) path; without it the output is pure BOC(1,1), slot_o/boc61_o are 0
// and epoch_i is ignored.
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   en_i            : run enable
//   fcw_i           : chip-rate frequency control word
//   chip_tick_o     : chip advance strobe to the generator
//   chip_i, epoch_i : chip and last-chip-of-code strobe from the generator
//   sample_o        : modulated sample (1 = +1, 0 = -1)
//   sample_valid_o  : sample_o carries a modulated chip
//   slot_o, boc61_o : SBOC slot of the output chip and its BOC(6,1) flag
module navic_boc_modulator
    import navic_boc_pkg::*;
#(
    parameter int FCW_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [FCW_W-1:0]  fcw_i,
    output logic              chip_tick_o,
    input  logic              chip_i,
    input  logic              epoch_i,
    output logic              sample_o,
    output logic              sample_valid_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              boc61_o
);

    logic               tick;
    logic [PHASE_W-1:0] phase;

    logic tick_q;
    logic chip_q, chip_d;
    logic en1_q;
    logic started_q, started_d;
    logic sample_q, sample_d;
    logic valid_q, valid_d;
    logic sc;

    navic_chip_nco #(
        .FCW_W(FCW_W)
    ) u_nco (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_i),
        .fcw_i  (fcw_i),
        .tick_o (tick),
        .phase_o(phase)
    );

    // The generator advances on the tick edge, so its new chip is on chip_i in
    // the following cycle, together with the first phase of that chip. The
    // sample is formed from these next-state values, which is the same as
    // chip_q XOR the one-clock-delayed phase, registered.
    always_comb begin
        chip_d    = tick_q ? chip_i : chip_q;
        started_d = started_q | tick_q;
        valid_d   = en1_q & (started_q | tick_q);
    end

`ifdef NAVIC_BOC_SBOC_EN
    logic              epoch_q, epoch_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              boc61_q, boc61_d;

    // Slot count restarts after the chip that carried the epoch strobe, and
    // wraps after SBOC_PERIOD chips; both at once still gives slot 0.
    always_comb begin
        epoch_d = epoch_q;
        slot_d  = slot_q;
        boc61_d = boc61_q;
        if (tick_q) begin
            epoch_d = epoch_i;
            if (epoch_q || (slot_q == SLOT_W'(SBOC_PERIOD - 1))) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + 1'b1;
            end
            boc61_d = isSbocSlot(slot_d);
        end
        sc = boc61_d ? boc61Subcarrier(phase) : phase[PHASE_W-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epoch_q <= 1'b0;
            slot_q  <= '0;
            boc61_q <= 1'b0;
        end else begin
            epoch_q <= epoch_d;
            slot_q  <= slot_d;
            boc61_q <= boc61_d;
        end
    end

    assign slot_o  = slot_q;
    assign boc61_o = boc61_q;
`else
    logic unusedEpoch;

    always_comb begin
        sc = phase[PHASE_W-1];
    end

    assign unusedEpoch = epoch_i;
    assign slot_o      = '0;
    assign boc61_o     = 1'b0;
`endif

    // tick_q and the valid pipeline run every clock: a tick already issued
    // must still be latched even if en_i drops in the next cycle, and the
    // sample register simply re-presents the held phase while paused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            chip_q    <= 1'b0;
            en1_q     <= 1'b0;
            started_q <= 1'b0;
            sample_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            tick_q    <= tick;
            chip_q    <= chip_d;
            en1_q     <= en_i;
            started_q <= started_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
        end
    end

    assign sample_d       = chip_d ^ sc;
    assign chip_tick_o    = tick;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_navic_boc_modulator.sv
// tb_navic_boc_modulator
// Drives the modulator with a behavioural pilot-code generator and compares
// every output, every clock, against a phase/chip-list reference model.
// Honors NAVIC_BOC_SBOC_EN the same way the design does.
module tb_navic_boc_modulator;

    localparam int FCW_W = 32;
    localparam longint unsigned WRAP = 64'd1 << 32;
    localparam longint unsigned HALF = 64'd1 << 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i;
    logic [31:0] fcw_i;
    logic        chip_tick_o;
    logic        chip_i;
    logic        epoch_i;
    logic        sample_o;
    logic        sample_valid_o;
    logic [5:0]  slot_o;
    logic        boc61_o;

    navic_boc_modulator #(.FCW_W(FCW_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .en_i          (en_i),
        .fcw_i         (fcw_i),
        .chip_tick_o   (chip_tick_o),
        .chip_i        (chip_i),
        .epoch_i       (epoch_i),
        .sample_o      (sample_o),
        .sample_valid_o(sample_valid_o),
        .slot_o        (slot_o),
        .boc61_o       (boc61_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: NCO phase as an integer, chips numbered from 1 after
    // reset, slot = (chip number - first chip after last epoch) mod 33.
    longint unsigned mAcc;
    int  chipCount, slotBase, curSlot;
    bit  curChip, curBoc, enPrev;
    bit  eSample, eValid, eBoc;
    int  eSlot;
    bit  genChip, genEpoch;

    bit  rstReq, enRandom, fcwRandom, chipForce, chipForceVal;
    int  epochMode;
    int  tickCount, cycleCount, firstTick, prevSlot;
    bit  sawWrap;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelIsSboc(input int s);
        return (s == 0) || (s == 4) || (s == 6) || (s == 29);
    endfunction

    function automatic bit modelSubcarrier(input longint unsigned acc, input bit useBoc61);
        int ph;
        ph = int'(acc >> 24);
        if (useBoc61) begin
            return (((ph * 12) / 256) % 2) == 1;
        end
        return ph >= 128;
    endfunction

    task automatic modelReset();
        mAcc = 0; chipCount = 0; slotBase = 0; curSlot = 0;
        curChip = 0; curBoc = 0; enPrev = 0;
        eSample = 0; eValid = 0; eSlot = 0; eBoc = 0;
        genChip = 0; genEpoch = 0;
    endtask

    // Generator advance on a tick: produce the next chip and its epoch flag.
    task automatic advanceGenerator();
        int nextSlot;
        chipCount++;
        nextSlot = (chipCount - slotBase) % 33;
        genChip = chipForce ? chipForceVal : bit'($urandom_range(0, 1));
        case (epochMode)
            1: genEpoch = ($urandom_range(0, 7) == 0);
            2: begin genEpoch = 1; epochMode = 0; end
            3: begin
                if (nextSlot == 32) begin genEpoch = 1; epochMode = 0; end
                else genEpoch = 0;
            end
            default: genEpoch = 0;
        endcase
        curChip = genChip;
`ifdef NAVIC_BOC_SBOC_EN
        curSlot = nextSlot;
        curBoc  = modelIsSboc(nextSlot);
`else
        curSlot = 0;
        curBoc  = 0;
`endif
        if (genEpoch) slotBase = chipCount + 1;
    endtask

    // One call per clock: drive inputs after the edge, check at the falling
    // edge, advance the model on the rising edge.
    task automatic applyStimulus(input int nCycles);
        longint unsigned fcwEff;
        bit eTick, nSample, nValid, nBoc;
        int nSlot;
        for (int i = 0; i < nCycles; i++) begin
            reset = rstReq;
            if (enRandom) en_i = ($urandom_range(0, 4) != 0);
            if (fcwRandom) fcw_i = $urandom;
            @(negedge clk);
            fcwEff = (64'(fcw_i) > HALF) ? HALF : 64'(fcw_i);
            eTick = en_i && ((mAcc + fcwEff) >= WRAP);
            checkOutput("chip_tick", int'(chip_tick_o), int'(eTick));
            checkOutput("sample_valid", int'(sample_valid_o), int'(eValid));
            if (eValid) checkOutput("sample", int'(sample_o), int'(eSample));
            if (reset) checkOutput("sample_in_reset", int'(sample_o), 0);
            checkOutput("slot", int'(slot_o), eSlot);
            checkOutput("boc61", int'(boc61_o), int'(eBoc));
            if (chip_tick_o) begin
                tickCount++;
                if (firstTick < 0) firstTick = cycleCount;
            end
            if (prevSlot == 32 && int'(slot_o) == 0) sawWrap = 1;
            prevSlot = int'(slot_o);
            cycleCount++;
            if (reset) begin
                nSample = 0; nValid = 0; nSlot = 0; nBoc = 0;
            end else begin
                nValid  = enPrev && (chipCount > 0);
                nSample = curChip ^ modelSubcarrier(mAcc, curBoc);
                nSlot   = (chipCount > 0) ? curSlot : 0;
                nBoc    = (chipCount > 0) ? curBoc : 0;
            end
            @(posedge clk);
            eSample = nSample; eValid = nValid; eSlot = nSlot; eBoc = nBoc;
            if (reset) begin
                modelReset();
            end else begin
                if (eTick) advanceGenerator();
                enPrev = en_i;
                if (en_i) mAcc = (mAcc + fcwEff) % WRAP;
            end
            #1;
            chip_i  = genChip;
            epoch_i = genEpoch;
        end
    endtask

    task automatic runUntilSlot(input int target, input int budget);
        int n;
        n = 0;
        while (int'(slot_o) != target && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("reach_slot", int'(slot_o), target);
    endtask

    task automatic powerOnCheck();
        rstReq = 0; tickCount = 0; cycleCount = 0; firstTick = -1;
        applyStimulus(40);
        checkOutput("ticks_after_reset", tickCount, 10);
        checkOutput("first_tick_cycle", firstTick, 3);
    endtask

    initial begin
        reset = 1; rstReq = 1; en_i = 1; fcw_i = 32'h4000_0000;
        chip_i = 0; epoch_i = 0;
        enRandom = 0; fcwRandom = 0; chipForce = 1; chipForceVal = 1; epochMode = 0;
        prevSlot = 0; sawWrap = 0; tickCount = 0; cycleCount = 0; firstTick = -1;
        modelReset();

        // Reset held, then power-on behaviour with chip_i = 1.
        applyStimulus(4);
        powerOnCheck();

        // BOC(1,1) with inverted chip.
        chipForceVal = 0;
        applyStimulus(40);

        // Random chips, enable and frequency word.
        chipForce = 0; enRandom = 1; fcwRandom = 1; epochMode = 1;
        applyStimulus(300);

        // SBOC alignment at 24 clocks per chip.
        enRandom = 0; fcwRandom = 0; en_i = 1; fcw_i = 32'h0AAA_AAAB; epochMode = 2;
        applyStimulus(30);
`ifdef NAVIC_BOC_SBOC_EN
        runUntilSlot(0, 120);
        checkOutput("boc61_slot0", int'(boc61_o), 1);
        runUntilSlot(4, 200);
        checkOutput("boc61_slot4", int'(boc61_o), 1);
        runUntilSlot(6, 100);
        checkOutput("boc61_slot6", int'(boc61_o), 1);
        runUntilSlot(29, 700);
        checkOutput("boc61_slot29", int'(boc61_o), 1);
        runUntilSlot(30, 60);
        checkOutput("boc61_slot30", int'(boc61_o), 0);
        sawWrap = 0;
        runUntilSlot(0, 120);
        checkOutput("slot_wrap_seen", int'(sawWrap), 1);
`else
        applyStimulus(900);
`endif

        // Epoch landing on slot 32.
        fcw_i = 32'h8000_0000; epochMode = 3;
        applyStimulus(160);

        // Hold mid-chip.
        fcw_i = 32'h0AAA_AAAB;
        applyStimulus(10);
        en_i = 0;
        applyStimulus(10);
        en_i = 1;
        applyStimulus(60);

        // Clamp: every other clock.
        fcw_i = 32'hFFFF_FFFF; tickCount = 0;
        applyStimulus(20);
        checkOutput("clamp_ticks", tickCount, 10);

        // Reset in the middle of a chip, in slot 4 when SBOC is built in.
        fcw_i = 32'h0AAA_AAAB;
`ifdef NAVIC_BOC_SBOC_EN
        runUntilSlot(4, 1000);
`endif
        applyStimulus(5);
        @(negedge clk);
        #2;
        reset = 1; rstReq = 1;
        #1;
        checkOutput("async_sample", int'(sample_o), 0);
        checkOutput("async_valid", int'(sample_valid_o), 0);
        checkOutput("async_slot", int'(slot_o), 0);
        checkOutput("async_boc61", int'(boc61_o), 0);
        checkOutput("async_tick", int'(chip_tick_o), 0);
        modelReset();
        chip_i = 0; epoch_i = 0;
        fcw_i = 32'h4000_0000; en_i = 1; chipForce = 1; chipForceVal = 1;
        applyStimulus(3);
        powerOnCheck();

        // Final random run.
        chipForce = 0; enRandom = 1; fcwRandom = 1; epochMode = 1;
        applyStimulus(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/navic_boc_modulator.md
# navic_boc_modulator

Chip-timing and subcarrier stage directly downstream of the NavIC L1 pilot code generator. An internal phase-accumulator NCO issues one `chip_tick_o` per chip; that pulse drives the generator's `ena`. The block latches the returned tiered pilot chip and modulates it onto a BOC subcarrier: BOC(1,1) for most chips, BOC(6,1) in the synthesized-BOC slots. The result is one sign-bit sample per `clk`, which feeds the DAC/IF stage.

## Interface
- `FCW_W`, default 32: width of the NCO accumulator and of `fcw_i`.
- `clk`, input, 1: sample clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `en_i`, input, 1: run enable. While low, the NCO and pipeline hold.
- `fcw_i`, input, FCW_W: chip-rate frequency control word, phase increment per clock.
- `chip_tick_o`, output, 1: chip advance strobe to the generator's `ena`.
- `chip_i`, input, 1: tiered pilot chip from the generator (its `uo_out[0]`).
- `epoch_i`, input, 1: last-chip-of-primary-code strobe from the generator (its `uo_out[3]`).
- `sample_o`, output, 1: modulated sample. 1 means +1, 0 means −1.
- `sample_valid_o`, output, 1: `sample_o` is meaningful.
- `slot_o`, output, 6: SBOC slot index (0..32) of the chip currently output.
- `boc61_o`, output, 1: the current output chip uses BOC(6,1).

## Operation
- NCO computation: `fcw_eff = min(fcw_i, 2^(FCW_W-1))`, then `{carry, acc_next} = acc + fcw_eff`.
  - Clamping guarantees at least 2 clocks per chip.
  - `chip_tick_o = en_i & carry`. This is combinational from the registered `acc` and `fcw_i`.
  - `acc` updates only when `en_i` is high.
- Chip latch: the cycle after a tick, `chip_i` and `epoch_i` are captured into `chip_q` and `epoch_q`. The generator has advanced by then.
- Slot counter, updated on each chip latch:
  - `slot = 0` if the previously latched `epoch_q` was 1, or if `slot == 32`.
  - Otherwise `slot + 1`.
  - Epoch and wrap occurring together give 0.
- SBOC slots are {0, 4, 6, 29} of each 33-chip block. `boc61 = (slot ∈ SBOC set)`.
- Subcarrier phase: `ph = acc[FCW_W-1:FCW_W-8]`, delayed one clock so it aligns with `chip_q`.
  - BOC(1,1): `sc = ph[7]`.
  - BOC(6,1): `seg = (ph*12) >> 8` (range 0..11, 12-bit product), `sc = seg[0]`.
- `sample_o = chip_q ^ sc`, registered.

## Timing
- Latency: `sample_o` equals the ideal modulated waveform for NCO phase `acc` delayed by exactly 2 clocks.
- Tick in cycle t:
  - The generator advances at the end of t.
  - `chip_q` is loaded at the end of t+1.
  - The first sample of the new chip appears in cycle t+2.
- `sample_valid_o` goes high 2 clocks after the first tick following reset. Earlier samples have no chip to modulate.
  - Thereafter it equals `en_i` delayed 2 clocks.
- Reset, asynchronous, acts immediately:
  - `acc = 0`, `chip_q = 0`, `epoch_q = 0`, `slot = 0`.
  - `sample_o = 0`, `sample_valid_o = 0`, `boc61_o = 0`, `slot_o = 0`, `chip_tick_o = 0`.
  - Reset mid-chip discards the chip.
- `en_i` low: `acc`, `slot` and `chip_q` hold, and `chip_tick_o = 0`. Resuming continues from the held phase with no missed chip.
- `fcw_i` changes take effect on the next clock edge. `fcw_i = 0` means no ticks.
- `fcw_i` above `2^(FCW_W-1)` is clamped, so ticks never occur on consecutive cycles.

## Configuration
- `NAVIC_BOC_SBOC_EN` defined:
  - Synthesized BOC is active.
  - The slot counter and BOC(6,1) multiplier are present.
- `NAVIC_BOC_SBOC_EN` undefined:
  - Pure BOC(1,1).
  - `boc61_o` is tied to 0 and `slot_o` to 0.
  - `epoch_i` is ignored.
  - The slot counter and multiplier are removed.

## Structure
- Package `navic_boc_pkg` holds:
  - the SBOC period constant (33);
  - the SBOC slot list {0, 4, 6, 29};
  - the BOC(6,1) segment count (12);
  - the phase-tap width (8).
- Sub-module `navic_chip_nco` contains the accumulator, FCW clamp and tick generation. The modulator instantiates it once.

## Test plan
- Reset values: hold `reset` high with `fcw_i = 0x4000_0000`.
  - Expect all outputs 0 and no ticks.
  - After release, expect a tick every 4 clocks and `sample_valid_o` high 2 clocks after the first tick.
- BOC(1,1) pattern: `fcw_i = 0x4000_0000`, `chip_i` held at 1, slot not SBOC.
  - Expect `sample_o` 1,1,0,0 per chip.
  - Expect 0,0,1,1 when `chip_i = 0`.
- SBOC alignment: `fcw_i = 0x0AAA_AAAB` (24 clocks per chip). Pulse `epoch_i` with one chip.
  - Expect the next chip to have `slot_o = 0` and `boc61_o = 1`.
  - Expect 12 alternating 2-clock half-periods.
  - Expect slots 4, 6 and 29 also to be BOC(6,1).
- Slot wrap: run 33 chips without an epoch.
  - Expect `slot_o` to go 32→0.
  - With an epoch on slot 32, expect the next slot to be 0.
- Hold and clamp:
  - `en_i` low for 10 clocks mid-chip: expect the phase held and no tick; the chip continues after release.
  - `fcw_i = 0xFFFF_FFFF`: expect a tick every 2 clocks.
- Reset mid-operation: assert `reset` mid-chip in BOC(6,1) slot 4.
  - Expect outputs cleared asynchronously.
  - Expect the restart to behave identically to power-on.
